// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised raster timing generator. A clock divider produces a pixel-rate
// strobe (pix_ce). On every strobe the horizontal/vertical position advances
// by one pixel over a configurable line/frame geometry. Sync, display-enable,
// position and line/frame markers are all decoded from the new position in
// the same registered stage, so they are always mutually aligned.
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   en          in   run enable; low freezes divider, position and levels
//   pix_ce      out  one-clk strobe: the timing outputs hold a new pixel
//   hsync       out  horizontal sync, asserted level = H_POL
//   vsync       out  vertical sync, asserted level = V_POL
//   de          out  display enable (visible area)
//   x           out  current pixel column  [CNT_W]
//   y           out  current line          [CNT_W]
//   line_start  out  high with pix_ce when x == 0
//   frame_start out  high with pix_ce when x == 0 and y == 0
//   frame_cnt   out  completed-frame count, wraps [FRM_W]
//
// Reset parks the position on the last pixel of the frame (deep in the back
// porch), so the first advance after reset lands on (0,0) and presents a
// clean frame_start.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int CNT_W    = 10,
  parameter int FRM_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             pix_ce,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start,
  output logic [FRM_W-1:0] frame_cnt
);

  // ---------------------------------------------------------------------------
  // Geometry
  // ---------------------------------------------------------------------------
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // A 1-bit divider is kept even for CLK_DIV == 1; it then never leaves 0.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_DE_LIM   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);

  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_DE_LIM   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic HS_ON = (H_POL != 0);
  localparam logic VS_ON = (V_POL != 0);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h
    $error("vga_timing_gen: horizontal sizes must all be >= 1");
  end
  if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v
    $error("vga_timing_gen: vertical sizes must all be >= 1");
  end
  if (CNT_W < 1 || CNT_W > 31 || FRM_W < 1) begin : g_bad_w
    $error("vga_timing_gen: CNT_W must be 1..31 and FRM_W >= 1");
  end
  if ((longint'(H_TOTAL) - 1) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_hw
    $error("vga_timing_gen: H_TOTAL-1 does not fit in CNT_W bits");
  end
  if ((longint'(V_TOTAL) - 1) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_vw
    $error("vga_timing_gen: V_TOTAL-1 does not fit in CNT_W bits");
  end

  // ---------------------------------------------------------------------------
  // Divider
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap;
  logic             tick;

  assign div_wrap = (div_cnt == DIV_LAST);
  // tick marks the edge on which the position advances; gated by en so a
  // frozen generator never emits a strobe.
  assign tick     = en && div_wrap;

  // ---------------------------------------------------------------------------
  // Next position and its decode
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] x_nxt;
  logic [CNT_W-1:0] y_nxt;
  logic             de_nxt;
  logic             hs_act_nxt;
  logic             vs_act_nxt;
  logic             origin_nxt;

  always_comb begin
    x_nxt = x + CNT_W'(1);
    y_nxt = y;
    if (x == H_LAST) begin
      x_nxt = '0;
      y_nxt = (y == V_LAST) ? '0 : (y + CNT_W'(1));
    end
  end

  // Decoding from the next position and registering together with it keeps
  // zero skew between x/y and every flag. vsync depends only on y, so it
  // naturally changes only where x wraps to 0.
  always_comb begin
    de_nxt     = (x_nxt < H_DE_LIM) && (y_nxt < V_DE_LIM);
    hs_act_nxt = (x_nxt >= H_SYNC_BEG) && (x_nxt <= H_SYNC_END);
    vs_act_nxt = (y_nxt >= V_SYNC_BEG) && (y_nxt <= V_SYNC_END);
    origin_nxt = (x_nxt == '0) && (y_nxt == '0);
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // seen_origin suppresses the frame count on the very first (0,0) after
  // reset, so frame_cnt counts completed frames only.
  logic seen_origin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt     <= '0;
      pix_ce      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      x           <= H_LAST;
      y           <= V_LAST;
      de          <= 1'b0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      frame_cnt   <= '0;
      seen_origin <= 1'b0;
    end else begin
      // Strobes are one clk wide and drop to 0 on the first edge with en=0.
      pix_ce      <= tick;
      line_start  <= tick && (x_nxt == '0);
      frame_start <= tick && origin_nxt;

      if (en) begin
        div_cnt <= div_wrap ? '0 : (div_cnt + DIV_W'(1));
      end

      if (tick) begin
        x     <= x_nxt;
        y     <= y_nxt;
        de    <= de_nxt;
        hsync <= hs_act_nxt ? HS_ON : ~HS_ON;
        vsync <= vs_act_nxt ? VS_ON : ~VS_ON;
        if (origin_nxt) begin
          seen_origin <= 1'b1;
          if (seen_origin) begin
            frame_cnt <= frame_cnt + FRM_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Three instances share one clock:
//   u_def   : default 640x480 geometry, CLK_DIV=2
//   u_med   : compact geometry (13x9, CLK_DIV=3, vsync active-high, 3-bit
//             frame counter) so whole frames and counter wrap fit in a short run
//   u_small : CLK_DIV=1, 8x6 geometry, both syncs active-high
// Each instance has its own rst/en and is held in reset until its tests run.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- default instance ----------------
  logic        d_rst = 1'b1, d_en = 1'b0;
  logic        d_pix_ce, d_hsync, d_vsync, d_de, d_ls, d_fs;
  logic [9:0]  d_x, d_y;
  logic [15:0] d_fc;

  vga_timing_gen u_def (
    .clk(clk), .rst(d_rst), .en(d_en), .pix_ce(d_pix_ce), .hsync(d_hsync),
    .vsync(d_vsync), .de(d_de), .x(d_x), .y(d_y), .line_start(d_ls),
    .frame_start(d_fs), .frame_cnt(d_fc)
  );

  // ---------------- medium instance ----------------
  logic       m_rst = 1'b1, m_en = 1'b0;
  logic       m_pix_ce, m_hsync, m_vsync, m_de, m_ls, m_fs;
  logic [3:0] m_x, m_y;
  logic [2:0] m_fc;

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(1),
    .H_POL(0), .V_POL(1), .CNT_W(4), .FRM_W(3)
  ) u_med (
    .clk(clk), .rst(m_rst), .en(m_en), .pix_ce(m_pix_ce), .hsync(m_hsync),
    .vsync(m_vsync), .de(m_de), .x(m_x), .y(m_y), .line_start(m_ls),
    .frame_start(m_fs), .frame_cnt(m_fc)
  );

  // ---------------- small instance ----------------
  logic       s_rst = 1'b1, s_en = 1'b0;
  logic       s_pix_ce, s_hsync, s_vsync, s_de, s_ls, s_fs;
  logic [2:0] s_x, s_y;
  logic [3:0] s_fc;

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1), .V_POL(1), .CNT_W(3), .FRM_W(4)
  ) u_small (
    .clk(clk), .rst(s_rst), .en(s_en), .pix_ce(s_pix_ce), .hsync(s_hsync),
    .vsync(s_vsync), .de(s_de), .x(s_x), .y(s_y), .line_start(s_ls),
    .frame_start(s_fs), .frame_cnt(s_fc)
  );

  // Advance one clock and settle just after the active edge.
  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int ce_seen;
    d_en  = 1'b1;
    d_rst = 1'b1;
    repeat (5) clk_step();
    n_cmp++; if (d_x !== 10'd799) begin n_bad++; $display("FAIL reset_x: got %0d want 799", d_x); end
    n_cmp++; if (d_y !== 10'd524) begin n_bad++; $display("FAIL reset_y: got %0d want 524", d_y); end
    n_cmp++; if ({d_de, d_hsync, d_vsync, d_pix_ce, d_ls, d_fs} !== 6'b011000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 011000", {d_de, d_hsync, d_vsync, d_pix_ce, d_ls, d_fs}); end
    n_cmp++; if (d_fc !== 16'd0) begin n_bad++; $display("FAIL reset_fc: got %0d want 0", d_fc); end

    d_rst = 1'b0;
    clk_step();
    ce_seen = d_pix_ce;
    n_cmp++; if (ce_seen !== 1) begin end
    if (d_pix_ce !== 1'b0) begin n_bad++; $display("FAIL start_gap: pix_ce got %b want 0", d_pix_ce); end
    clk_step();
    n_cmp++; if (d_pix_ce !== 1'b1) begin n_bad++; $display("FAIL start_ce: got %b want 1", d_pix_ce); end
    n_cmp++; if (d_x !== 10'd0 || d_y !== 10'd0) begin n_bad++; $display("FAIL start_pos: got (%0d,%0d) want (0,0)", d_x, d_y); end
    n_cmp++; if ({d_fs, d_ls, d_de, d_hsync, d_vsync} !== 5'b11111) begin
      n_bad++; $display("FAIL start_flags: got %b want 11111", {d_fs, d_ls, d_de, d_hsync, d_vsync}); end
    n_cmp++; if (d_fc !== 16'd0) begin n_bad++; $display("FAIL start_fc: got %0d want 0", d_fc); end
  endtask

  // ---------------------------------------------------------------------------
  // One full line on the default geometry, starting from the (0,0) sample.
  task automatic test_hline();
    int exp_x = 0, ce_cnt = 0, ce_odd = 0, pos_err = 0, de_cnt = 0;
    int hs_cnt = 0, hs_first = -1, hs_last = -1, ls_cnt = 0, vs_err = 0;
    for (int i = 0; i <= 1600; i++) begin
      if (i > 0) clk_step();
      if (d_pix_ce) begin
        ce_cnt++;
        if (i % 2 == 1) ce_odd++;
        if (i < 1600) begin
          if (d_x !== 10'(exp_x) || d_y !== 10'd0) pos_err++;
          if (d_de) de_cnt++;
          if (!d_hsync) begin
            hs_cnt++;
            if (hs_first < 0) hs_first = int'(d_x);
            hs_last = int'(d_x);
          end
          if (d_ls) ls_cnt++;
          if (d_vsync !== 1'b1) vs_err++;
          exp_x++;
        end
      end
    end
    n_cmp++; if (ce_cnt != 801) begin n_bad++; $display("FAIL line_ce_count: got %0d want 801", ce_cnt); end
    n_cmp++; if (ce_odd != 0) begin n_bad++; $display("FAIL line_ce_phase: got %0d odd strobes want 0", ce_odd); end
    n_cmp++; if (pos_err != 0) begin n_bad++; $display("FAIL line_x_seq: got %0d errors want 0", pos_err); end
    n_cmp++; if (de_cnt != 640) begin n_bad++; $display("FAIL line_de_count: got %0d want 640", de_cnt); end
    n_cmp++; if (hs_cnt != 96) begin n_bad++; $display("FAIL line_hs_count: got %0d want 96", hs_cnt); end
    n_cmp++; if (hs_first != 656 || hs_last != 751) begin
      n_bad++; $display("FAIL line_hs_range: got %0d..%0d want 656..751", hs_first, hs_last); end
    n_cmp++; if (ls_cnt != 1) begin n_bad++; $display("FAIL line_ls_count: got %0d want 1", ls_cnt); end
    n_cmp++; if (vs_err != 0) begin n_bad++; $display("FAIL line_vsync: got %0d errors want 0", vs_err); end
    n_cmp++; if (d_x !== 10'd0 || d_y !== 10'd1 || {d_pix_ce, d_ls, d_fs} !== 3'b110) begin
      n_bad++; $display("FAIL line_wrap: got (%0d,%0d) ce/ls/fs=%b want (0,1) 110", d_x, d_y, {d_pix_ce, d_ls, d_fs}); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_freeze();
    int w = 0, hold_err = 0;
    while (!(d_pix_ce === 1'b1 && d_x === 10'd100) && w < 400) begin
      clk_step();
      w++;
    end
    n_cmp++; if (w >= 400) begin n_bad++; $display("FAIL freeze_reach: x=100 not reached, got x=%0d", d_x); end
    d_en = 1'b0;
    for (int i = 0; i < 37; i++) begin
      clk_step();
      if (d_pix_ce !== 1'b0 || d_x !== 10'd100 || d_y !== 10'd1 || d_de !== 1'b1 ||
          d_hsync !== 1'b1 || d_vsync !== 1'b1 || d_ls !== 1'b0 || d_fs !== 1'b0) hold_err++;
    end
    n_cmp++; if (hold_err != 0) begin n_bad++; $display("FAIL freeze_hold: got %0d bad cycles want 0", hold_err); end
    d_en = 1'b1;
    clk_step();
    n_cmp++; if (d_pix_ce !== 1'b0 || d_x !== 10'd100) begin
      n_bad++; $display("FAIL resume_gap: got ce=%b x=%0d want ce=0 x=100", d_pix_ce, d_x); end
    clk_step();
    n_cmp++; if (d_pix_ce !== 1'b1 || d_x !== 10'd101 || d_y !== 10'd1) begin
      n_bad++; $display("FAIL resume_next: got ce=%b (%0d,%0d) want ce=1 (101,1)", d_pix_ce, d_x, d_y); end
  endtask

  // ---------------------------------------------------------------------------
  // Ten frame_starts on the compact geometry; stats over the nine full frames.
  task automatic test_frame();
    int exp_x = 0, exp_y = 0, gap = 0, gap_err = 0, dec_err = 0, fs_seen = 0;
    int last_fs = 0, per_err = 0, fc_err = 0, fc_at3 = -1, ce_pre = 0;
    int de_cnt = 0, hs_cnt = 0, vs_cnt = 0, ce_cnt = 0, ls_cnt = 0;
    int vs_ymin = 99, vs_ymax = -1, vs_edge_bad = 0;
    logic prev_vs;
    m_en  = 1'b1;
    m_rst = 1'b1;
    repeat (3) clk_step();
    n_cmp++; if (m_x !== 4'd12 || m_y !== 4'd8) begin n_bad++; $display("FAIL med_reset_pos: got (%0d,%0d) want (12,8)", m_x, m_y); end
    n_cmp++; if ({m_de, m_hsync, m_vsync, m_pix_ce, m_ls, m_fs} !== 6'b010000 || m_fc !== 3'd0) begin
      n_bad++; $display("FAIL med_reset_flags: got %b fc=%0d want 010000 fc=0", {m_de, m_hsync, m_vsync, m_pix_ce, m_ls, m_fs}, m_fc); end
    m_rst = 1'b0;
    clk_step(); if (m_pix_ce) ce_pre++;
    clk_step(); if (m_pix_ce) ce_pre++;
    n_cmp++; if (ce_pre != 0) begin n_bad++; $display("FAIL med_start_gap: got %0d strobes want 0", ce_pre); end
    clk_step();
    n_cmp++; if (m_pix_ce !== 1'b1 || m_x !== 4'd0 || m_y !== 4'd0 || m_fs !== 1'b1) begin
      n_bad++; $display("FAIL med_start: got ce=%b (%0d,%0d) fs=%b want ce=1 (0,0) fs=1", m_pix_ce, m_x, m_y, m_fs); end

    prev_vs = m_vsync;
    for (int i = 0; i < 4000 && fs_seen < 10; i++) begin
      if (i > 0) clk_step();
      gap++;
      if (m_pix_ce) begin
        if (i > 0 && gap != 3) gap_err++;
        gap = 0;
        if (m_x !== 4'(exp_x) || m_y !== 4'(exp_y)) dec_err++;
        if (m_fs !== (exp_x == 0 && exp_y == 0)) dec_err++;
        if (m_ls !== (exp_x == 0)) dec_err++;
        if (m_de !== (exp_x < 6 && exp_y < 4)) dec_err++;
        if (m_hsync !== !(exp_x >= 8 && exp_x <= 10)) dec_err++;
        if (m_vsync !== (exp_y >= 6 && exp_y <= 7)) dec_err++;
        if (m_fs) begin
          if (m_fc !== 3'(fs_seen % 8)) fc_err++;
          if (fs_seen == 3) fc_at3 = int'(m_fc);
          if (fs_seen > 0 && (i - last_fs) != 351) per_err++;
          last_fs = i;
          fs_seen++;
        end
        if (fs_seen >= 1 && fs_seen <= 9) begin
          ce_cnt++;
          if (m_de) de_cnt++;
          if (!m_hsync) hs_cnt++;
          if (m_ls) ls_cnt++;
          if (m_vsync) begin
            vs_cnt++;
            if (int'(m_y) < vs_ymin) vs_ymin = int'(m_y);
            if (int'(m_y) > vs_ymax) vs_ymax = int'(m_y);
          end
        end
        if (m_vsync !== prev_vs && m_x !== 4'd0) vs_edge_bad++;
        prev_vs = m_vsync;
        exp_x++;
        if (exp_x == 13) begin exp_x = 0; exp_y = (exp_y + 1) % 9; end
      end
    end
    n_cmp++; if (fs_seen != 10) begin n_bad++; $display("FAIL frame_reach: got %0d frame_starts want 10", fs_seen); end
    n_cmp++; if (gap_err != 0) begin n_bad++; $display("FAIL frame_ce_gap: got %0d errors want 0", gap_err); end
    n_cmp++; if (dec_err != 0) begin n_bad++; $display("FAIL frame_decode: got %0d errors want 0", dec_err); end
    n_cmp++; if (per_err != 0) begin n_bad++; $display("FAIL frame_period: got %0d errors want 0", per_err); end
    n_cmp++; if (fc_err != 0) begin n_bad++; $display("FAIL frame_cnt_seq: got %0d errors want 0", fc_err); end
    n_cmp++; if (fc_at3 != 3) begin n_bad++; $display("FAIL frame_cnt_4th: got %0d want 3", fc_at3); end
    n_cmp++; if (m_fc !== 3'd1) begin n_bad++; $display("FAIL frame_cnt_wrap: got %0d want 1", m_fc); end
    n_cmp++; if (ce_cnt != 1053) begin n_bad++; $display("FAIL frame_ce_count: got %0d want 1053", ce_cnt); end
    n_cmp++; if (de_cnt != 216) begin n_bad++; $display("FAIL frame_de_count: got %0d want 216", de_cnt); end
    n_cmp++; if (hs_cnt != 243) begin n_bad++; $display("FAIL frame_hs_count: got %0d want 243", hs_cnt); end
    n_cmp++; if (vs_cnt != 234) begin n_bad++; $display("FAIL frame_vs_count: got %0d want 234", vs_cnt); end
    n_cmp++; if (ls_cnt != 81) begin n_bad++; $display("FAIL frame_ls_count: got %0d want 81", ls_cnt); end
    n_cmp++; if (vs_ymin != 6 || vs_ymax != 7) begin n_bad++; $display("FAIL frame_vs_range: got %0d..%0d want 6..7", vs_ymin, vs_ymax); end
    n_cmp++; if (vs_edge_bad != 0) begin n_bad++; $display("FAIL frame_vs_edge: got %0d edges off x=0 want 0", vs_edge_bad); end
  endtask

  // ---------------------------------------------------------------------------
  // Freeze while the divider is mid-count; it must resume from the held count.
  task automatic test_freeze_mid();
    logic [3:0] x0, y0;
    int hold_err = 0;
    x0 = m_x;
    y0 = m_y;
    clk_step();
    m_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      clk_step();
      if (m_pix_ce !== 1'b0 || m_x !== x0 || m_y !== y0) hold_err++;
    end
    n_cmp++; if (hold_err != 0) begin n_bad++; $display("FAIL med_freeze_hold: got %0d bad cycles want 0", hold_err); end
    m_en = 1'b1;
    clk_step();
    n_cmp++; if (m_pix_ce !== 1'b0) begin n_bad++; $display("FAIL med_resume_gap: pix_ce got %b want 0", m_pix_ce); end
    clk_step();
    n_cmp++; if (m_pix_ce !== 1'b1 || m_x !== x0 + 4'd1 || m_y !== y0) begin
      n_bad++; $display("FAIL med_resume_next: got ce=%b (%0d,%0d) want ce=1 (%0d,%0d)", m_pix_ce, m_x, m_y, x0 + 4'd1, y0); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_async_reset();
    int w = 0, ce_pre = 0, n = 0;
    while (!(m_pix_ce === 1'b1 && m_x === 4'd3 && m_y === 4'd2) && w < 400) begin
      clk_step();
      w++;
    end
    n_cmp++; if (w >= 400) begin n_bad++; $display("FAIL arst_reach: (3,2) not reached, got (%0d,%0d)", m_x, m_y); end
    #3;
    m_rst = 1'b1;
    #1;
    n_cmp++; if (m_x !== 4'd12 || m_y !== 4'd8) begin n_bad++; $display("FAIL arst_pos: got (%0d,%0d) want (12,8)", m_x, m_y); end
    n_cmp++; if ({m_de, m_hsync, m_vsync, m_pix_ce, m_ls, m_fs} !== 6'b010000 || m_fc !== 3'd0) begin
      n_bad++; $display("FAIL arst_flags: got %b fc=%0d want 010000 fc=0", {m_de, m_hsync, m_vsync, m_pix_ce, m_ls, m_fs}, m_fc); end
    repeat (3) clk_step();
    m_rst = 1'b0;
    clk_step(); if (m_pix_ce) ce_pre++;
    clk_step(); if (m_pix_ce) ce_pre++;
    n_cmp++; if (ce_pre != 0) begin n_bad++; $display("FAIL arst_start_gap: got %0d strobes want 0", ce_pre); end
    clk_step();
    n_cmp++; if (m_pix_ce !== 1'b1 || m_x !== 4'd0 || m_y !== 4'd0 || m_fs !== 1'b1 || m_fc !== 3'd0) begin
      n_bad++; $display("FAIL arst_restart: got ce=%b (%0d,%0d) fs=%b fc=%0d want ce=1 (0,0) fs=1 fc=0", m_pix_ce, m_x, m_y, m_fs, m_fc); end
    do begin
      clk_step();
      n++;
    end while (m_fs !== 1'b1 && n < 400);
    n_cmp++; if (n != 351 || m_fc !== 3'd1) begin
      n_bad++; $display("FAIL arst_next_frame: got %0d clk fc=%0d want 351 clk fc=1", n, m_fc); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_small();
    int exp_x = 0, exp_y = 0, ce_low = 0, dec_err = 0, fs_cnt = 0, fs_bad = 0;
    int ls_cnt = 0, ls_bad = 0, hold_err = 0;
    s_en  = 1'b1;
    s_rst = 1'b1;
    repeat (3) clk_step();
    n_cmp++; if (s_x !== 3'd7 || s_y !== 3'd5 || {s_de, s_hsync, s_vsync, s_pix_ce, s_ls, s_fs} !== 6'b000000 || s_fc !== 4'd0) begin
      n_bad++; $display("FAIL small_reset: got (%0d,%0d) %b fc=%0d want (7,5) 000000 fc=0",
                        s_x, s_y, {s_de, s_hsync, s_vsync, s_pix_ce, s_ls, s_fs}, s_fc); end
    s_rst = 1'b0;
    clk_step();
    n_cmp++; if (s_pix_ce !== 1'b1 || s_x !== 3'd0 || s_y !== 3'd0 || {s_fs, s_ls, s_de, s_hsync, s_vsync} !== 5'b11100) begin
      n_bad++; $display("FAIL small_start: got ce=%b (%0d,%0d) %b want ce=1 (0,0) 11100",
                        s_pix_ce, s_x, s_y, {s_fs, s_ls, s_de, s_hsync, s_vsync}); end
    for (int i = 0; i <= 96; i++) begin
      if (i > 0) clk_step();
      if (s_pix_ce !== 1'b1) ce_low++;
      if (s_x !== 3'(exp_x) || s_y !== 3'(exp_y)) dec_err++;
      if (s_de !== (exp_x < 4 && exp_y < 3)) dec_err++;
      if (s_hsync !== (exp_x >= 5 && exp_x <= 6)) dec_err++;
      if (s_vsync !== (exp_y == 4)) dec_err++;
      if (s_fs) begin fs_cnt++; if (i % 48 != 0) fs_bad++; end
      if (s_ls) begin ls_cnt++; if (i % 8 != 0) ls_bad++; end
      exp_x++;
      if (exp_x == 8) begin exp_x = 0; exp_y = (exp_y + 1) % 6; end
    end
    n_cmp++; if (ce_low != 0) begin n_bad++; $display("FAIL small_ce_const: got %0d low cycles want 0", ce_low); end
    n_cmp++; if (dec_err != 0) begin n_bad++; $display("FAIL small_decode: got %0d errors want 0", dec_err); end
    n_cmp++; if (fs_cnt != 3 || fs_bad != 0) begin n_bad++; $display("FAIL small_frame_period: got %0d starts %0d misplaced want 3 0", fs_cnt, fs_bad); end
    n_cmp++; if (ls_cnt != 13 || ls_bad != 0) begin n_bad++; $display("FAIL small_line_period: got %0d starts %0d misplaced want 13 0", ls_cnt, ls_bad); end
    n_cmp++; if (s_fc !== 4'd2) begin n_bad++; $display("FAIL small_fc: got %0d want 2", s_fc); end
    s_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clk_step();
      if (s_pix_ce !== 1'b0 || s_x !== 3'd0 || s_y !== 3'd0 || s_fs !== 1'b0 || s_ls !== 1'b0 || s_de !== 1'b1) hold_err++;
    end
    n_cmp++; if (hold_err != 0) begin n_bad++; $display("FAIL small_freeze: got %0d bad cycles want 0", hold_err); end
    s_en = 1'b1;
    clk_step();
    n_cmp++; if (s_pix_ce !== 1'b1 || s_x !== 3'd1 || s_y !== 3'd0) begin
      n_bad++; $display("FAIL small_resume: got ce=%b (%0d,%0d) want ce=1 (1,0)", s_pix_ce, s_x, s_y); end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_hline();
    test_freeze();
    test_frame();
    test_freeze_mid();
    test_async_reset();
    test_small();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
